// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared types, window constants and result scaling for the stochastic stream decoder (SC_DECODE_BIPOLAR_EN selects bipolar scaling)
package sc_pkg;

    localparam int SC_WIN_LOG2 = 8;
    localparam int SC_OUT_W    = 8;
    localparam int WIN_LEN     = 1 << SC_WIN_LOG2;
    localparam int HALF_WIN    = WIN_LEN / 2;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } sc_dec_state_t;

    // Turns a window ones-count into the output code: drop the extra window
    // resolution, then clamp so an all-ones window reads as full scale.
    function automatic logic [31:0] sc_scale(input logic [31:0] ones,
                                             input int          win_log2,
                                             input int          out_w);
        int shift;
        shift = win_log2 - out_w;
`ifdef SC_DECODE_BIPOLAR_EN
        begin
            logic signed [31:0] v;
            logic signed [31:0] s;
            logic signed [31:0] hi;
            logic signed [31:0] lo;
            // Centre the count on half a window so p=0.5 decodes to zero.
            v  = $signed(ones) - (32'sd1 <<< (win_log2 - 1));
            s  = v >>> shift;
            hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
            lo = -hi - 32'sd1;
            if (s > hi) begin
                s = hi;
            end else if (s < lo) begin
                s = lo;
            end
            return s;
        end
`else
        begin
            logic [31:0] s;
            logic [31:0] hi;
            s  = ones >> shift;
            hi = (32'd1 << out_w) - 32'd1;
            if (s > hi) begin
                s = hi;
            end
            return s;
        end
`endif
    endfunction

endpackage

// File: rtl/sc_window_counter.sv
// rtl/sc_window_counter.sv - per-window sample and ones counters with clear, accept and last-sample flag
module sc_window_counter
    import sc_pkg::*;
#(
    parameter int WIN_LOG2 = SC_WIN_LOG2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              clear,
    input  logic              accept,
    input  logic              bit_in,
    output logic [WIN_LOG2:0] ones_total,
    output logic              last
);

    logic [WIN_LOG2-1:0] samples_q;
    logic [WIN_LOG2:0]   ones_q;

    // Clear wins over accept: on the final sample the parent captures the
    // total from ones_total and restarts the window in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samples_q <= '0;
            ones_q    <= '0;
        end else if (ena) begin
            if (clear) begin
                samples_q <= '0;
                ones_q    <= '0;
            end else if (accept) begin
                samples_q <= samples_q + 1'b1;
                ones_q    <= ones_q + {{WIN_LOG2{1'b0}}, bit_in};
            end
        end
    end

    // Running total including the bit presented this cycle, so the final
    // sample's contribution is visible before it is registered.
    always_comb begin
        ones_total = ones_q + {{WIN_LOG2{1'b0}}, bit_in};
        last       = &samples_q;
    end

endmodule

// File: rtl/sc_stream_decoder.sv
// rtl/sc_stream_decoder.sv - stochastic bitstream to binary decoder top (SC_DECODE_BIPOLAR_EN selects bipolar result)
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int WIN_LOG2 = SC_WIN_LOG2,
    parameter int OUT_W    = SC_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             continuous,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic             result_valid,
    output logic [OUT_W-1:0] result
);

    sc_dec_state_t     state_q;
    sc_dec_state_t     state_d;
    logic              cnt_clear;
    logic              accept;
    logic              final_accept;
    logic              last;
    logic [WIN_LOG2:0] ones_total;
    logic [OUT_W-1:0]  scaled;
    logic              done_q;
    logic              result_valid_q;
    logic [OUT_W-1:0]  result_q;

    assign busy         = (state_q == COUNT);
    assign accept       = ena & busy & bit_valid;
    assign final_accept = accept & last;
    assign scaled       = OUT_W'(sc_scale(32'(ones_total), WIN_LOG2, OUT_W));

    sc_window_counter #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .clear      (cnt_clear),
        .accept     (accept),
        .bit_in     (bit_in),
        .ones_total (ones_total),
        .last       (last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    // Next state and counter clear; a start on the final sample lets the
    // window complete and then keeps counting regardless of continuous.
    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (ena && start) begin
                    state_d   = COUNT;
                    cnt_clear = 1'b1;
                end
            end
            COUNT: begin
                if (final_accept) begin
                    cnt_clear = 1'b1;
                    state_d   = (continuous || start) ? COUNT : IDLE;
                end else if (ena && start) begin
                    cnt_clear = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result capture and done pulse one cycle after the final sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
        end else if (ena) begin
            done_q <= final_accept;
            if (final_accept) begin
                result_q       <= scaled;
                result_valid_q <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done         = done_q & ena;
    assign result_valid = result_valid_q;
    assign result       = result_q;

endmodule
